// File: rtl/exc_seq_pkg.sv
// Shared constants for the exception sequencer: ExcCode values, FSM state
// encoding and the default handler entry PC.
package exc_seq_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_EXC     = 3'd1;
    localparam logic [2:0] ST_REDIR_H = 3'd2;
    localparam logic [2:0] ST_RET     = 3'd3;
    localparam logic [2:0] ST_REDIR_E = 3'd4;

    localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_4180;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: picks the single winning interrupt or
// exception for the M-stage instruction and returns its ExcCode.
module exc_prio_enc
    import exc_seq_pkg::*;
(
    input  logic       int_req,
    input  logic [4:0] exc,      // {AdES, AdEL_data, Ov, RI, AdEL_fetch}
    input  logic       syscall,
    output logic       take,
    output logic [4:0] code
);

    always_comb begin
        take = 1'b1;
        code = EXC_INT;
        if (int_req)        code = EXC_INT;
        else if (exc[0])    code = EXC_ADEL;
        else if (exc[1])    code = EXC_RI;
        else if (exc[2])    code = EXC_OV;
        else if (syscall)   code = EXC_SYS;
        else if (exc[3])    code = EXC_ADEL;
        else if (exc[4])    code = EXC_ADES;
        else                take = 1'b0;
    end

endmodule

// File: rtl/exc_seq.sv
// Exception/interrupt sequencer between M stage and CP0. Define
// EXC_SEQ_IRQ_SYNC_EN to pass irq through a 2-flop synchronizer.
module exc_seq
    import exc_seq_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT,
    parameter int          IRQ_W        = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IRQ_W-1:0] irq,
    input  logic             m_valid,
    input  logic             m_stall,
    input  logic [31:0]      m_pc,
    input  logic             m_bd,
    input  logic [4:0]       m_exc,
    input  logic             m_syscall,
    input  logic             m_eret,
    input  logic [IRQ_W-1:0] sr_im,
    input  logic             sr_ie,
    input  logic             sr_exl,
    input  logic [31:0]      cp0_epc,
    output logic             exc_we,
    output logic [4:0]       exc_code,
    output logic [31:0]      exc_epc,
    output logic             exc_bd,
    output logic [IRQ_W-1:0] exc_ip,
    output logic             exl_clr,
    output logic             flush,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    logic [IRQ_W-1:0] irq_s;
    logic [IRQ_W-1:0] ip_now;
    logic             int_req;
    logic             sample;
    logic             enc_take;
    logic [4:0]       enc_code;
    logic             exc_take;
    logic             ret_take;
    logic [2:0]       state;
    logic [2:0]       state_nx;

`ifdef EXC_SEQ_IRQ_SYNC_EN
    logic [IRQ_W-1:0] irq_q1;
    logic [IRQ_W-1:0] irq_q2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q1 <= '0;
            irq_q2 <= '0;
        end else begin
            irq_q1 <= irq;
            irq_q2 <= irq_q1;
        end
    end

    assign irq_s = irq_q2;
`else
    assign irq_s = irq;
`endif

    assign ip_now  = irq_s & sr_im;
    assign int_req = (|ip_now) & sr_ie & ~sr_exl;
    // Events only on a real, moving instruction so EPC is always precise.
    assign sample  = (state == ST_IDLE) & m_valid & ~m_stall;

    exc_prio_enc u_prio (
        .int_req (int_req),
        .exc     (m_exc),
        .syscall (m_syscall),
        .take    (enc_take),
        .code    (enc_code)
    );

    assign exc_take = sample & enc_take;
    assign ret_take = sample & m_eret & ~enc_take;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (exc_take)      state_nx = ST_EXC;
                else if (ret_take) state_nx = ST_RET;
            end
            ST_EXC:     state_nx = ST_REDIR_H;
            ST_REDIR_H: state_nx = ST_IDLE;
            ST_RET:     state_nx = ST_REDIR_E;
            ST_REDIR_E: state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            exc_we      <= 1'b0;
            exl_clr     <= 1'b0;
            flush       <= 1'b0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            exc_code    <= '0;
            exc_epc     <= '0;
            exc_bd      <= 1'b0;
            exc_ip      <= '0;
        end else begin
            state       <= state_nx;
            exc_we      <= (state_nx == ST_EXC);
            exl_clr     <= (state_nx == ST_RET);
            flush       <= (state_nx != ST_IDLE);
            redir_valid <= (state_nx == ST_REDIR_H) | (state_nx == ST_REDIR_E);
            if (state_nx == ST_REDIR_H)      redir_pc <= HANDLER_ADDR;
            else if (state_nx == ST_REDIR_E) redir_pc <= cp0_epc;
            else                             redir_pc <= '0;
            if (exc_take) begin
                exc_code <= enc_code;
                exc_epc  <= m_bd ? m_pc - 32'd4 : m_pc;
                exc_bd   <= m_bd;
                exc_ip   <= ip_now;
            end
        end
    end

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_exc_seq.sv
// Bench for exc_seq: spec vector table, randomized events against a rule
// model, and hand sequences for reset, deferral and stall.
module tb_exc_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  irq = '0;
    logic        m_valid = 1'b0;
    logic        m_stall = 1'b0;
    logic [31:0] m_pc = '0;
    logic        m_bd = 1'b0;
    logic [4:0]  m_exc = '0;
    logic        m_syscall = 1'b0;
    logic        m_eret = 1'b0;
    logic [5:0]  sr_im = '0;
    logic        sr_ie = 1'b0;
    logic        sr_exl = 1'b0;
    logic [31:0] cp0_epc = '0;
    logic        exc_we;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic        exc_bd;
    logic [5:0]  exc_ip;
    logic        exl_clr;
    logic        flush;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        busy;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exc_seq dut (
        .clk         (clk),
        .reset       (reset),
        .irq         (irq),
        .m_valid     (m_valid),
        .m_stall     (m_stall),
        .m_pc        (m_pc),
        .m_bd        (m_bd),
        .m_exc       (m_exc),
        .m_syscall   (m_syscall),
        .m_eret      (m_eret),
        .sr_im       (sr_im),
        .sr_ie       (sr_ie),
        .sr_exl      (sr_exl),
        .cp0_epc     (cp0_epc),
        .exc_we      (exc_we),
        .exc_code    (exc_code),
        .exc_epc     (exc_epc),
        .exc_bd      (exc_bd),
        .exc_ip      (exc_ip),
        .exl_clr     (exl_clr),
        .flush       (flush),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // kind: 0 = nothing taken, 1 = exception/interrupt, 2 = ERET
    typedef struct {
        logic [5:0]  irq;
        logic [5:0]  sr_im;
        logic        sr_ie;
        logic        sr_exl;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic        sys;
        logic        eret;
        logic [31:0] epc_in;
        int          kind;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd_o;
        logic [5:0]  ip;
        logic [31:0] redir;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model written from the priority table and EPC rules.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        logic intr;
        r = v;
        r.ip = v.irq & v.sr_im;
        r.epc = v.bd ? v.pc - 32'd4 : v.pc;
        r.bd_o = v.bd;
        r.kind = 1;
        r.redir = 32'h0000_4180;
        intr = (r.ip != 0) && v.sr_ie && !v.sr_exl;
        if (intr)           r.code = 5'd0;
        else if (v.exc[0])  r.code = 5'd4;
        else if (v.exc[1])  r.code = 5'd10;
        else if (v.exc[2])  r.code = 5'd12;
        else if (v.sys)     r.code = 5'd8;
        else if (v.exc[3])  r.code = 5'd4;
        else if (v.exc[4])  r.code = 5'd5;
        else begin
            r.code = 5'd0;
            if (v.eret) begin
                r.kind = 2;
                r.redir = v.epc_in;
            end else begin
                r.kind = 0;
            end
        end
        return r;
    endfunction

    task automatic drive_idle_inputs(input vec_t v);
        irq = v.irq; sr_im = v.sr_im; sr_ie = v.sr_ie; sr_exl = v.sr_exl;
        m_pc = v.pc; m_bd = v.bd; m_exc = v.exc; m_syscall = v.sys;
        m_eret = v.eret; cp0_epc = v.epc_in;
        m_valid = 1'b0; m_stall = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        drive_idle_inputs(v);
        repeat (3) @(negedge clk);
        m_valid = 1'b1;
        @(posedge clk);
        #1 m_valid = 1'b0;
        @(negedge clk);
        if (v.kind == 1) begin
            chk({tag, " t1_exc_we"}, exc_we, 1);
            chk({tag, " t1_exl_clr"}, exl_clr, 0);
            chk({tag, " t1_flush"}, flush, 1);
            chk({tag, " t1_code"}, exc_code, v.code);
            chk({tag, " t1_epc"}, exc_epc, v.epc);
            chk({tag, " t1_bd"}, exc_bd, v.bd_o);
            chk({tag, " t1_ip"}, exc_ip, v.ip);
        end else if (v.kind == 2) begin
            chk({tag, " t1_exc_we"}, exc_we, 0);
            chk({tag, " t1_exl_clr"}, exl_clr, 1);
            chk({tag, " t1_flush"}, flush, 1);
        end else begin
            chk({tag, " t1_busy"}, busy, 0);
            chk({tag, " t1_exc_we"}, exc_we, 0);
            chk({tag, " t1_exl_clr"}, exl_clr, 0);
        end
        chk({tag, " t1_redir_valid"}, redir_valid, 0);
        if (v.kind != 0) begin
            chk({tag, " t1_busy"}, busy, 1);
            @(negedge clk);
            chk({tag, " t2_redir_valid"}, redir_valid, 1);
            chk({tag, " t2_redir_pc"}, redir_pc, v.redir);
            chk({tag, " t2_flush"}, flush, 1);
            chk({tag, " t2_pulses"}, {exc_we, exl_clr}, 0);
            @(negedge clk);
            chk({tag, " t3_busy"}, busy, 0);
            chk({tag, " t3_flush"}, flush, 0);
            chk({tag, " t3_redir_valid"}, redir_valid, 0);
        end
    endtask

    vec_t tbl[10];
    vec_t rv;

    initial begin
        // irq, im, ie, exl, pc, bd, exc, sys, eret, epc_in | kind, code, epc, bd, ip, redir
        tbl[0] = '{6'b000100, 6'h3F, 1, 0, 32'h3010, 0, 5'b00000, 0, 0, 32'h0, 1, 5'd0,  32'h3010, 0, 6'b000100, 32'h4180};
        tbl[1] = '{6'b000000, 6'h3F, 1, 0, 32'h3008, 1, 5'b00010, 0, 0, 32'h0, 1, 5'd10, 32'h3004, 1, 6'b000000, 32'h4180};
        tbl[2] = '{6'b000000, 6'h3F, 1, 0, 32'h3100, 0, 5'b00100, 1, 0, 32'h0, 1, 5'd12, 32'h3100, 0, 6'b000000, 32'h4180};
        tbl[3] = '{6'b000001, 6'h3F, 1, 1, 32'h3104, 0, 5'b00100, 1, 0, 32'h0, 1, 5'd12, 32'h3104, 0, 6'b000001, 32'h4180};
        tbl[4] = '{6'b000000, 6'h3F, 1, 1, 32'h3040, 0, 5'b00000, 0, 1, 32'h3020, 2, 5'd0, 32'h0, 0, 6'b0, 32'h3020};
        tbl[5] = '{6'b000000, 6'h3F, 1, 1, 32'h3050, 0, 5'b00010, 0, 1, 32'h3020, 1, 5'd10, 32'h3050, 0, 6'b0, 32'h4180};
        tbl[6] = '{6'b000010, 6'b111101, 1, 0, 32'h3060, 0, 5'b00000, 0, 0, 32'h0, 0, 5'd0, 32'h0, 0, 6'b0, 32'h0};
        tbl[7] = '{6'b100000, 6'h3F, 0, 0, 32'h3070, 0, 5'b10000, 0, 0, 32'h0, 1, 5'd5, 32'h3070, 0, 6'b100000, 32'h4180};
        tbl[8] = '{6'b000000, 6'h3F, 1, 0, 32'h0, 1, 5'b00001, 0, 0, 32'h0, 1, 5'd4, 32'hFFFF_FFFC, 1, 6'b0, 32'h4180};
        tbl[9] = '{6'b000000, 6'h3F, 1, 0, 32'h3080, 0, 5'b11000, 0, 0, 32'h0, 1, 5'd4, 32'h3080, 0, 6'b0, 32'h4180};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_outs", {exc_we, exl_clr, flush, redir_valid}, 0);
        chk("rst_redir_pc", redir_pc, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            rv.irq = 6'($urandom_range(0, 63));
            rv.sr_im = 6'($urandom_range(0, 63));
            rv.sr_ie = 1'($urandom_range(0, 1));
            rv.sr_exl = 1'($urandom_range(0, 1));
            rv.pc = {$urandom(), 2'b00} ;
            rv.bd = 1'($urandom_range(0, 1));
            rv.exc = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
            rv.sys = ($urandom_range(0, 3) == 0);
            rv.eret = ($urandom_range(0, 2) == 0);
            rv.epc_in = {$urandom(), 2'b00};
            rv = model(rv);
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        // Interrupt deferred across bubbles and a stall, then taken precisely.
        @(negedge clk);
        irq = 6'b000100; sr_im = 6'h3F; sr_ie = 1; sr_exl = 0;
        m_exc = 0; m_syscall = 0; m_eret = 0; m_bd = 0; m_pc = 32'h3200;
        m_valid = 0; m_stall = 0;
        repeat (3) begin
            @(negedge clk);
            chk("defer_bubble_busy", busy, 0);
        end
        m_valid = 1; m_stall = 1;
        @(negedge clk);
        chk("defer_stall_busy", busy, 0);
        chk("defer_stall_we", exc_we, 0);
        m_stall = 0;
        @(posedge clk);
        #1 m_valid = 0;
        @(negedge clk);
        chk("defer_we", exc_we, 1);
        chk("defer_epc", exc_epc, 32'h3200);
        @(negedge clk);
        chk("defer_we_one_cycle", exc_we, 0);
        @(negedge clk);

        // Reset asserted mid-EXC drops everything at once.
        m_exc = 5'b00010; irq = 0; m_pc = 32'h3300;
        repeat (3) @(negedge clk);
        m_valid = 1;
        @(posedge clk);
        #1 m_valid = 0;
        chk("midrst_pre_we", exc_we, 1);
        reset = 1'b0;
        #1;
        chk("midrst_outs", {exc_we, exl_clr, flush, redir_valid, busy}, 0);
        chk("midrst_code", exc_code, 0);
        chk("midrst_epc", exc_epc, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_after_busy", busy, 0);
        chk("midrst_after_redir", redir_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exc_seq.md
Name: exc_seq

Overview:
- Exception/interrupt sequencer between the pipeline M stage and the CP0 register file.
- Samples device interrupt lines and per-instruction exception flags, picks one winner per event, and drives CP0 write strobes (cause code, EPC, BD, EXL set) and the ERET EXL clear.
- Sequences the pipeline flush and PC redirect to the handler or to EPC through a small FSM.
- Sits beside CP0; the pipeline sees it only through flush/redirect.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, exception/interrupt handler entry PC.
- IRQ_W, 6, number of hardware interrupt lines (maps to Cause/Status bits 15:10).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (low = reset asserted).
- irq  in  IRQ_W  device interrupt levels.
- m_valid  in  1  M stage holds a real instruction (not a bubble).
- m_stall  in  1  M stage frozen this cycle.
- m_pc  in  32  PC of the M-stage instruction.
- m_bd  in  1  M instruction is in a branch delay slot.
- m_exc  in  5  flags {AdES, AdEL_data, Ov, RI, AdEL_fetch}, bit0 = AdEL_fetch.
- m_syscall  in  1  M instruction is SYSCALL.
- m_eret  in  1  M instruction is ERET.
- sr_im  in  IRQ_W  Status.IM from CP0.
- sr_ie  in  1  Status.IE from CP0.
- sr_exl  in  1  Status.EXL from CP0.
- cp0_epc  in  32  current EPC from CP0.
- exc_we  out  1  one-cycle pulse: CP0 must load Cause/EPC/BD and set EXL.
- exc_code  out  5  ExcCode for CP0 Cause[6:2].
- exc_epc  out  32  value to write into EPC.
- exc_bd  out  1  Cause.BD value.
- exc_ip  out  IRQ_W  masked pending lines for Cause.IP.
- exl_clr  out  1  one-cycle pulse: CP0 clears EXL (ERET).
- flush  out  1  kill IF..M instructions.
- redir_valid  out  1  one-cycle pulse: load redir_pc into PC.
- redir_pc  out  32  redirect target.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (reset low, asynchronous): FSM = IDLE; all outputs 0; synchronizer flops 0.
- Interrupt request: int_req = |(irq_s & sr_im) & sr_ie & ~sr_exl, where irq_s is the irq lines as seen by the block (see Optional Feature).
- Sampling: events are evaluated only when IDLE & m_valid & ~m_stall. A bubble or stall defers the event; a pending interrupt waits for the next valid instruction so EPC is precise.
- Priority, highest first, with ExcCode:
  - Int 0
  - AdEL_fetch 4
  - RI 10
  - Ov 12
  - Syscall 8
  - AdEL_data 4
  - AdES 5
- ERET is handled only if none of the above fires.
- EPC = m_bd ? m_pc - 32'd4 : m_pc (32-bit wrap). exc_bd = m_bd. exc_ip = irq_s & sr_im, latched at the sample cycle.
- FSM states:
  - IDLE: exception or interrupt taken at cycle T -> EXC. ERET taken -> RET. Otherwise stay.
  - EXC (cycle T+1): exc_we = 1, flush = 1; code/EPC/BD/IP are registered values from T. -> REDIR_H.
  - REDIR_H (T+2): flush = 1, redir_valid = 1, redir_pc = HANDLER_ADDR. -> IDLE.
  - RET (T+1): exl_clr = 1, flush = 1. -> REDIR_E.
  - REDIR_E (T+2): flush = 1, redir_valid = 1, redir_pc = cp0_epc sampled this cycle. -> IDLE.
- Outputs are registered and depend on state only.
- busy = 1 in every state except IDLE. Inputs are ignored while busy, so new events are taken no earlier than T+3.
- While sr_exl = 1, interrupts are blocked; synchronous exceptions are still taken and overwrite EPC.
- Reset asserted mid-sequence: immediate return to IDLE; partial pulses are dropped.
- m_eret together with any m_exc bit: the exception wins and exl_clr is not pulsed.

Optional Feature:
- EXC_SEQ_IRQ_SYNC_EN defined: irq passes through a 2-flop synchronizer (reset to 0); interrupt latency grows by 2 cycles.
- Undefined: irq_s = irq, used combinationally.

Decomposition:
- Shared package: ExcCode constants (EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_RI=10, EXC_OV=12), FSM state encoding, default HANDLER_ADDR.
- One sub-module: exc_prio_enc (combinational priority encoder -> take, code).

Test Plan:
- Reset low mid-EXC -> all outputs 0 at once; after reset high, busy = 0.
- irq = 6'b000100, sr_im = 6'h3F, sr_ie = 1, sr_exl = 0, m_valid = 1, m_pc = 0x3010 -> T+1 exc_we = 1, code 0, epc 0x3010, exc_ip 6'b000100; T+2 redir_pc = 0x4180.
- RI with m_bd = 1, m_pc = 0x3008 -> exc_code 10, exc_epc 0x3004, exc_bd = 1.
- Ov and Syscall together -> code 12; irq also pending with sr_exl = 1 -> still code 12 (interrupt masked).
- m_eret = 1, cp0_epc = 0x3020 -> T+1 exl_clr = 1 and no exc_we; T+2 redir_pc = 0x3020. Repeat with RI set -> code 10, no exl_clr.
- Interrupt pending while m_valid = 0 for 3 cycles, then valid -> exc_we exactly one cycle after the first valid sample.
